// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - tear-free four-digit seven-segment scan driver with hex decode and leading-zero blanking
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        value_valid,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] held_value,
  output logic        frame_tick
);

  // Prescaler width; a divider of 2 still needs one bit.
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);

  // Capture stage: most recent value from the processor.
  logic [15:0]   held_value_q, held_value_d;
  logic [3:0]    held_dp_q, held_dp_d;

  // Scan timing.
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          slot_tick;
  logic          frame_wrap;

  // Frame buffer: only reloaded at the digit-3 to digit-0 wrap so a frame never mixes two values.
  logic [15:0]   frame_value_q, frame_value_d;
  logic [3:0]    frame_dp_q, frame_dp_d;
  logic          frame_tick_q, frame_tick_d;

  // Output register: everything on the pins comes straight from flops.
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  // Digit selection and decode.
  logic [3:0]    nib;
  logic [15:0]   upper_bits;
  logic          digit_blank;
  logic [6:0]    seg_decoded;

  // Capture on a valid strobe unless the display is frozen.
  always_comb begin
    held_value_d = held_value_q;
    held_dp_d    = held_dp_q;
    if (value_valid && !freeze) begin
      held_value_d = value_in;
      held_dp_d    = dp_in;
    end
  end

  // Prescaler, digit index and frame-buffer reload; the reload uses the pre-edge held value.
  always_comb begin
    slot_tick     = (pcnt_q == PCNT_MAX);
    frame_wrap    = slot_tick && (idx_q == 2'd3);
    pcnt_d        = slot_tick ? '0 : pcnt_q + 1'b1;
    idx_d         = slot_tick ? idx_q + 2'd1 : idx_q;
    frame_value_d = frame_wrap ? held_value_q : frame_value_q;
    frame_dp_d    = frame_wrap ? held_dp_q : frame_dp_q;
    frame_tick_d  = frame_wrap;
  end

  // Pick the current nibble and decide whether it is a blanked leading zero.
  always_comb begin
    nib         = frame_value_q[{idx_q, 2'b00} +: 4];
    upper_bits  = frame_value_q >> {idx_q, 2'b00};
    digit_blank = blank_lz && (idx_q != 2'd0) && (upper_bits == 16'h0000);
  end

  // Active-low hex decode, bit order g..a.
  always_comb begin
    seg_decoded = 7'b1111111;
    case (nib)
      4'h0: seg_decoded = 7'b1000000;
      4'h1: seg_decoded = 7'b1111001;
      4'h2: seg_decoded = 7'b0100100;
      4'h3: seg_decoded = 7'b0110000;
      4'h4: seg_decoded = 7'b0011001;
      4'h5: seg_decoded = 7'b0010010;
      4'h6: seg_decoded = 7'b0000010;
      4'h7: seg_decoded = 7'b1111000;
      4'h8: seg_decoded = 7'b0000000;
      4'h9: seg_decoded = 7'b0010000;
      4'hA: seg_decoded = 7'b0001000;
      4'hB: seg_decoded = 7'b0000011;
      4'hC: seg_decoded = 7'b1000110;
      4'hD: seg_decoded = 7'b0100001;
      4'hE: seg_decoded = 7'b0000110;
      4'hF: seg_decoded = 7'b0001110;
      default: seg_decoded = 7'b1111111;
    endcase
  end

  // Next pin state; anode and segments come from the same index so they switch together.
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = digit_blank ? 7'b1111111 : seg_decoded;
    dp_d  = digit_blank ? 1'b1 : ~frame_dp_q[idx_q];
  end

  // All state; reset drives the display dark immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_value_q  <= 16'h0000;
      held_dp_q     <= 4'h0;
      pcnt_q        <= '0;
      idx_q         <= 2'd0;
      frame_value_q <= 16'h0000;
      frame_dp_q    <= 4'h0;
      frame_tick_q  <= 1'b0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= 4'hF;
    end else begin
      held_value_q  <= held_value_d;
      held_dp_q     <= held_dp_d;
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      frame_value_q <= frame_value_d;
      frame_dp_q    <= frame_dp_d;
      frame_tick_q  <= frame_tick_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign held_value = held_value_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed table-driven bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        value_valid;
  logic        freeze;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] held_value;
  logic        frame_tick;

  int checks;
  int errors;

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .value_valid(value_valid),
    .freeze     (freeze),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .held_value (held_value),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dpv;
    logic            blank;
    logic [3:0][6:0] segs;
    logic [3:0]      dpn;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a one-cycle strobe, then step one extra negedge so any stale frame_tick is gone.
  task automatic capture(input logic [15:0] v, input logic [3:0] d);
    value_in    = v;
    dp_in       = d;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_tick_seen", {15'd0, frame_tick}, 16'd1);
  endtask

  // Check one whole frame: digits 0..3, each held four cycles.
  task automatic check_frame(input string name, input logic [3:0][6:0] segs, input logic [3:0] dpn);
    logic [3:0] an_exp;
    wait_frame();
    for (int d = 0; d < 4; d++) begin
      an_exp = ~(4'b0001 << d);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check({name, "_an"}, {12'd0, an}, {12'd0, an_exp});
        check({name, "_seg"}, {9'd0, seg}, {9'd0, segs[d]});
        check({name, "_dp"}, {15'd0, dp}, {15'd0, dpn[d]});
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    value_in    = 16'h0000;
    dp_in       = 4'h0;
    value_valid = 1'b0;
    freeze      = 1'b0;
    blank_lz    = 1'b0;

    vecs[0] = '{16'h1A3F, 4'b0000, 1'b0, {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b1111};
    vecs[1] = '{16'h0123, 4'b1001, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30}, 4'b0110};
    vecs[2] = '{16'h4567, 4'b0000, 1'b0, {7'h19, 7'h12, 7'h02, 7'h78}, 4'b1111};
    vecs[3] = '{16'h89AB, 4'b0000, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b1111};
    vecs[4] = '{16'hCDEF, 4'b0000, 1'b0, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1111};
    vecs[5] = '{16'h0030, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1111};
    vecs[6] = '{16'h0000, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};
    vecs[7] = '{16'h0012, 4'b0100, 1'b0, {7'h40, 7'h40, 7'h79, 7'h24}, 4'b1011};
    vecs[8] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_seg", {9'd0, seg}, 16'h007F);
    check("rst_an", {12'd0, an}, 16'h000F);
    check("rst_dp", {15'd0, dp}, 16'd1);
    check("rst_held", held_value, 16'h0000);
    check("rst_ftick", {15'd0, frame_tick}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_an", {12'd0, an}, 16'h000E);
    check("rel_seg", {9'd0, seg}, 16'h0040);
    check("rel_dp", {15'd0, dp}, 16'd1);

    // Table of captures, each checked over the first full frame after it lands
    for (int i = 0; i < 9; i++) begin
      blank_lz = vecs[i].blank;
      capture(vecs[i].value, vecs[i].dpv);
      check("held", held_value, vecs[i].value);
      check_frame("vec", vecs[i].segs, vecs[i].dpn);
    end
    blank_lz = 1'b0;

    // Capture and scan over two consecutive frames
    capture(16'h1A3F, 4'b0000);
    check_frame("scan1", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b1111);
    check_frame("scan2", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b1111);

    // Tearing guard: second capture lands on the wrap edge itself
    capture(16'h1234, 4'b0000);
    wait_frame();
    repeat (15) @(negedge clk);
    value_in    = 16'h5678;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    check("tear_ftick", {15'd0, frame_tick}, 16'd1);
    check("tear_held", held_value, 16'h5678);
    check_frame("tear_old", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
    check_frame("tear_new", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111);

    // Freeze: strobe ignored, display unchanged
    freeze = 1'b1;
    capture(16'hBEEF, 4'b1111);
    check("frz_held", held_value, 16'h5678);
    check_frame("frz", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111);
    freeze = 1'b0;

    // Reset asserted mid-scan goes dark at once, then restarts on digit 0 showing 0
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_seg", {9'd0, seg}, 16'h007F);
    check("mid_rst_an", {12'd0, an}, 16'h000F);
    check("mid_rst_held", held_value, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_an", {12'd0, an}, 16'h000E);
    check("mid_rel_seg", {9'd0, seg}, 16'h0040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Single-clock replacement for the display path that consumes the processor's `ResultW[15:0]` and drives the Basys3 four-digit seven-segment display. It captures a 16-bit value on a valid strobe and holds it in a frame buffer that updates only at scan-frame boundaries, so digits never tear. It time-multiplexes the four digits with an internal prescaler tick instead of a divided clock, and decodes hex nibbles with optional leading-zero blanking.

## Interface
Parameters:
- `REFRESH_DIV`, 100000: `clk` cycles per digit slot (100 MHz → 1 kHz digit rate). Legal range is 2 or more. The prescaler is `$clog2(REFRESH_DIV)` bits wide.

Ports:
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: reset, asynchronous, active-low.
- `value_in` in 16: value to display; connected to `ResultW[15:0]`.
- `dp_in` in 4: decimal-point request per digit, 1 = lit; `dp_in[i]` belongs to digit i.
- `value_valid` in 1: one-cycle capture strobe.
- `freeze` in 1: while 1, captures are ignored.
- `blank_lz` in 1: enables leading-zero blanking.
- `seg` out 7: active-low segments; `seg[0]`=a … `seg[6]`=g.
- `dp` out 1: active-low decimal point.
- `an` out 4: active-low digit enables; `an[0]` is the rightmost digit, which shows the least-significant nibble.
- `held_value` out 16: most recently captured value.
- `frame_tick` out 1: one-cycle pulse when the frame buffer reloads.

## Operation
- Capture stage:
  - When `value_valid && !freeze`, `held_value <= value_in` and `held_dp <= dp_in` on the next edge.
  - When `value_valid` is 0, or `freeze` is 1, `held_*` keep their values.
- Prescaler:
  - `pcnt` counts 0 .. `REFRESH_DIV-1`, then wraps to 0.
  - `slot_tick` is asserted when `pcnt == REFRESH_DIV-1`.
- Digit index `idx[1:0]` advances on `slot_tick` in the order 0→1→2→3→0.
- Frame buffer:
  - On a `slot_tick` while `idx == 3` (the wrap), `frame_value <= held_value` and `frame_dp <= held_dp`, using pre-edge values.
  - `frame_tick` pulses in the same edge.
- Simultaneous capture and wrap in one cycle: the frame loads the old `held_value`, and the new value appears at the next wrap.
- Digit select:
  - `nib = frame_value[4*idx +: 4]`.
  - Digit `idx` is blanked when `blank_lz`=1, `idx != 0`, and `frame_value[15:4*idx] == 0`.
  - Digit 0 is never blanked.
- Decode is a full hex table, active-low, listed as g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Blanked digit: `seg` = 1111111 and `dp` = 1.
- Output register:
  - `an <= ~(4'b0001 << idx)`.
  - `seg <= decode` or blank.
  - `dp <= ~frame_dp[idx]`.
  - `seg`, `dp` and `an` are all registered; there is no combinational path from inputs to the pins.
- Exactly one `an` bit is low at any time after the first output update. No ghosting: `an` and `seg` change in the same edge.

## Timing
- Reset values:
  - `seg`=7'h7F, `dp`=1, `an`=4'hF (display dark).
  - `held_value`=0, `frame_value`=0, `held_dp`=0, `frame_dp`=0.
  - `pcnt`=0, `idx`=0, `frame_tick`=0.
- Output register loads every cycle from the current `idx`.
- First edge after `rst` deasserts: `an`=4'b1110, showing digit 0 = "0".
- `idx` changes one cycle after `slot_tick`; `an` and `seg` reflect the new digit one cycle after that.
- Slot period is `REFRESH_DIV` cycles; frame period is 4×`REFRESH_DIV` cycles.
- Capture-to-pin latency ranges from 1 cycle plus up to 4×`REFRESH_DIV` cycles to the frame wrap, plus 1 cycle into the output register.
- Reset asserted mid-frame: all state returns to reset values asynchronously and the display goes dark immediately.
- `value_valid` held high for several cycles: each cycle recaptures, and the last value before the wrap is displayed.

## Test plan
All scenarios use `REFRESH_DIV`=4.
- Reset: pulse `rst` low mid-scan → `seg`=7F and `an`=F during reset. First cycle after release: `an`=1110, `seg`=1000000.
- Capture and scan:
  - Stimulus: `value_in`=16'h1A3F with `value_valid` for one cycle, then run 2 frames.
  - Response: after the first wrap (`frame_tick`), `an[0]` shows F=0001110, `an[1]` shows 3=0110000, `an[2]` shows A=0001000, `an[3]` shows 1=1111001.
  - Each digit is held for 4 cycles.
- Tearing guard: capture 16'h1234, then capture 16'h5678 on the same cycle as the idx-3 `slot_tick` → that frame shows 1234 and the next frame shows 5678.
- Freeze: `freeze`=1 while strobing 16'hBEEF → `held_value` and the display are unchanged.
- Blanking:
  - Stimulus: `blank_lz`=1, value 16'h0030.
  - Response: digits 3 and 2 are dark (`seg`=7F), digit 1 = "3", digit 0 = "0".
  - With value 0, only digit 0 is lit.
- Decimal point: `dp_in`=4'b0100 with value 16'h0012 → `dp`=0 only while `an`=1011.
